// File: rtl/scr1_ahb_mem_resp.sv
// AHB-Lite memory responder backed by a flop-array RAM, with programmable wait states and a two-cycle ERROR response.
// Latency: data phase lasts wait_cfg+1 cycles; hready low during inserted waits and the ERROR first cycle.
module scr1_ahb_mem_resp #(
    parameter int MEM_POWER_SIZE = 16,
    parameter int WAIT_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic [1:0]        htrans,
    input  logic [31:0]       haddr,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic [31:0]       hwdata,
    output logic              hready,
    output logic [31:0]       hrdata,
    output logic              hresp
);

    localparam int AW    = MEM_POWER_SIZE - 2;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                    state_q, state_d;
    logic [WAIT_W-1:0]         cnt_q, cnt_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic [MEM_POWER_SIZE-1:0] addr_q, addr_d;
    logic [1:0]                size_q, size_d;
    logic                      write_q, write_d;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        legal;
    logic        last_cyc;
    logic [3:0]  be;
    logic [AW-1:0] word_idx;

    assign word_idx = addr_q[MEM_POWER_SIZE-1:2];
    assign last_cyc = (state_q == ST_DATA) && (cnt_q == wait_q);

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        case (state_q)
            ST_DATA: hready = last_cyc;
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    // Only NONSEQ/SEQ start a transfer; IDLE and BUSY complete as zero-wait OKAY.
    assign accept = hready && ((htrans == 2'b10) || (htrans == 2'b11));

    always_comb begin
        legal = 1'b1;
        if (hsize > 3'd2)                         legal = 1'b0;
        if ((hsize == 3'd1) && haddr[0])          legal = 1'b0;
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) legal = 1'b0;
        if (|haddr[31:MEM_POWER_SIZE])            legal = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            ST_DATA: begin
                if (last_cyc) state_d = ST_IDLE;
                else          cnt_d   = cnt_q + WAIT_W'(1);
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        // accept is only possible in a completing cycle, so it overrides the above.
        if (accept) begin
            addr_d  = haddr[MEM_POWER_SIZE-1:0];
            size_d  = hsize[1:0];
            write_d = hwrite;
            wait_d  = wait_cfg;
            cnt_d   = '0;
            state_d = legal ? ST_DATA : ST_ERR1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be[addr_q[1:0]] = 1'b1;
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // RAM is deliberately not reset; state_q is IDLE throughout reset so no write can slip in.
    always_ff @(posedge clk) begin
        if (last_cyc && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    assign hrdata = (last_cyc && !write_q) ? mem[word_idx] : 32'h0;

endmodule

// File: tb/tb_scr1_ahb_mem_resp.sv
// Scoreboard bench for scr1_ahb_mem_resp: directed AHB transfers, expected responses queued at issue time.
module tb_scr1_ahb_mem_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  wait_cfg;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;

    scr1_ahb_mem_resp #(.MEM_POWER_SIZE(16), .WAIT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wait_cfg (wait_cfg),
        .htrans   (htrans),
        .haddr    (haddr),
        .hsize    (hsize),
        .hwrite   (hwrite),
        .hwdata   (hwdata),
        .hready   (hready),
        .hrdata   (hrdata),
        .hresp    (hresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   pending  = 0;
    bit   err2_next = 0;
    int   waits    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: tracks data phases from observed accepts and pops the scoreboard at each completion.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (err2_next) begin
                chk("err2_hready", 32'(hready), 32'd1);
                chk("err2_hresp", 32'(hresp), 32'd1);
                err2_next = 0;
            end else if (pending) begin
                if (!hready && hresp) begin
                    pending = 0;
                    err2_next = 1;
                    if (q.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("err_expected", 32'(e.is_err), 32'd1);
                    end
                end else if (!hready) begin
                    waits++;
                    if (waits > 60) begin
                        chk("wait_timeout", 32'(waits), 32'd60);
                        pending = 0;
                    end
                end else begin
                    pending = 0;
                    if (q.size() == 0) chk("unexpected_xfer", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("okay_expected", 32'(e.is_err), 32'd0);
                        chk("hresp_okay", 32'(hresp), 32'd0);
                        chk("hrdata", hrdata, e.data);
                        chk("wait_cycles", 32'(waits), 32'(e.waits));
                    end
                end
            end
            if (hready && htrans[1]) begin
                pending = 1;
                waits = 0;
            end
        end
    end

    always @(negedge rst_n) begin
        pending = 0;
        err2_next = 0;
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input int w, input bit err,
                         input logic [31:0] rd_exp, input bit push);
        exp_t e;
        int t;
        wait_cfg = 4'(w);
        htrans   = 2'b10;
        haddr    = a;
        hsize    = sz;
        hwrite   = wr;
        if (push) begin
            e.is_err = err;
            e.data   = (wr || err) ? 32'h0 : rd_exp;
            e.waits  = w;
            q.push_back(e);
        end
        t = 0;
        while (!hready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) chk("accept_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        htrans = 2'b00;
        hwdata = wd;
    endtask

    task automatic drain();
        int t;
        t = 0;
        htrans = 2'b00;
        while ((q.size() != 0 || pending || err2_next) && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 200) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wait_cfg = '0;
        htrans = 2'b00;
        haddr = '0;
        hsize = 3'd2;
        hwrite = 1'b0;
        hwdata = '0;
        #2;
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait pipelined writes then read-after-write
        issue(1, 32'h0,   3'd2, 32'h11111111, 0, 0, 0, 1);
        issue(1, 32'h100, 3'd2, 32'hDEADBEEF, 0, 0, 0, 1);
        issue(0, 32'h100, 3'd2, 32'h0,        0, 0, 32'hDEADBEEF, 1);
        issue(1, 32'h200, 3'd2, 32'hCAFEF00D, 0, 0, 0, 1);
        drain();

        // Three wait states; wait_cfg drop mid-transfer must not shorten it
        issue(0, 32'h100, 3'd2, 32'h0, 3, 0, 32'hDEADBEEF, 1);
        wait_cfg = 4'd0;
        drain();

        // Byte lane 2, then half lanes 0-1
        issue(1, 32'h102, 3'd0, 32'h00550000, 0, 0, 0, 1);
        issue(1, 32'h100, 3'd1, 32'h0000AAAA, 0, 0, 0, 1);
        issue(0, 32'h100, 3'd2, 32'h0, 0, 0, 32'hDE55AAAA, 1);
        drain();

        // Illegal accesses; the read after the last error is issued in ERR2
        issue(1, 32'h102,   3'd2, 32'hFFFFFFFF, 0, 1, 0, 1);
        issue(1, 32'h0,     3'd3, 32'hFFFFFFFF, 0, 1, 0, 1);
        issue(1, 32'h10000, 3'd2, 32'hFFFFFFFF, 0, 1, 0, 1);
        issue(0, 32'h100,   3'd2, 32'h0, 0, 0, 32'hDE55AAAA, 1);
        issue(0, 32'h0,     3'd2, 32'h0, 2, 0, 32'h11111111, 1);
        drain();

        // Reset in wait cycle 2 abandons a pending write
        issue(1, 32'h200, 3'd2, 32'h12345678, 5, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_hready", 32'(hready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_hready", 32'(hready), 32'd1);
        chk("midrst_hresp", 32'(hresp), 32'd0);
        chk("midrst_hrdata", hrdata, 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(0, 32'h200, 3'd2, 32'h0, 0, 0, 32'hCAFEF00D, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
